// File: rtl/mod_pkg.sv
// mod_pkg: shared types and constants for the symbol sequencer
package mod_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] PRE_SYM_EVEN = 2'b00;
  localparam logic [SYM_W-1:0] PRE_SYM_ODD = 2'b11;
endpackage

// File: rtl/mod_symbol_sequencer_if.sv
// mod_symbol_sequencer_if: byte stream in, symbol select and status out
// master = byte source / mux side, slave = sequencer
interface mod_symbol_sequencer_if;
  import mod_pkg::*;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic [SYM_W-1:0] sel;
  logic sym_strobe;
  logic busy;
  logic burst_done;
  modport master(output in_valid, in_data, input in_ready, sel, sym_strobe, busy, burst_done);
  modport slave(input in_valid, in_data, output in_ready, sel, sym_strobe, busy, burst_done);
endinterface

// File: rtl/mod_symbol_timer.sv
// mod_symbol_timer: per-symbol cycle counter giving registered strobe and last-cycle flag
// ports: clk, rst, run (busy now), run_next (busy next cycle), sym_strobe, last
module mod_symbol_timer #(
  parameter int SYM_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic run_next,
  output logic sym_strobe,
  output logic last
);
  localparam int CW = SYM_CYCLES > 1 ? $clog2(SYM_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic strobe_q, strobe_d;
  always_comb begin
    last = run && cnt_q == CW'(SYM_CYCLES - 1);
    cnt_d = run && !last ? cnt_q + 1'b1 : '0;
    strobe_d = run_next && cnt_d == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      strobe_q <= strobe_d;
    end
  end
  assign sym_strobe = strobe_q;
endmodule

// File: rtl/mod_symbol_sequencer.sv
// mod_symbol_sequencer: splits bytes into 2-bit symbols with a preamble per burst
// ports: clk, rst (async, active-high), bus (slave): in_valid/in_data/in_ready, sel, sym_strobe, busy, burst_done
module mod_symbol_sequencer
  import mod_pkg::*;
#(
  parameter int SYM_CYCLES = 4,
  parameter int PREAMBLE_SYMS = 4,
  parameter logic [SYM_W-1:0] IDLE_SEL = 2'd0
) (
  input logic clk,
  input logic rst,
  mod_symbol_sequencer_if.slave bus
);
  localparam int IW = PREAMBLE_SYMS > 4 ? $clog2(PREAMBLE_SYMS) : 2;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, hold_q, hold_d;
  logic [SYM_W-1:0] sel_q, sel_d;
  logic hold_valid_q, hold_valid_d, busy_q, busy_d, done_q, done_d, last, load, hs;
  mod_symbol_timer #(.SYM_CYCLES(SYM_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(busy_q),
    .run_next(busy_d),
    .sym_strobe(bus.sym_strobe),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    load = 1'b0;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (hold_valid_q) state_d = PREAMBLE;
    end else if (last) begin
      idx_d = idx_q + 1'b1;
      if (state_q == PREAMBLE && idx_q == IW'(PREAMBLE_SYMS - 1)) begin
        load = 1'b1;
        state_d = DATA;
        idx_d = '0;
      end else if (state_q == DATA && idx_q == IW'(3)) begin
        // a waiting byte continues the burst without a new preamble
        idx_d = '0;
        load = hold_valid_q;
        state_d = hold_valid_q ? DATA : IDLE;
        done_d = !hold_valid_q;
      end
    end
    hs = bus.in_valid && !hold_valid_q;
    shift_d = load ? hold_q : shift_q;
    hold_d = hs ? bus.in_data : hold_q;
    hold_valid_d = hs || (hold_valid_q && !load);
    busy_d = state_d != IDLE;
    // symbol j of the byte sits at bits [7-2j -: 2]
    sel_d = state_d == IDLE ? IDLE_SEL :
            state_d == PREAMBLE ? (idx_d[0] ? PRE_SYM_ODD : PRE_SYM_EVEN) :
            shift_d[{~idx_d[1:0], 1'b0} +: SYM_W];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sel_q <= IDLE_SEL;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sel_q <= sel_d;
    end
  end
  assign bus.in_ready = !hold_valid_q;
  assign bus.sel = sel_q;
  assign bus.busy = busy_q;
  assign bus.burst_done = done_q;
endmodule

// File: tb/tb_mod_symbol_sequencer.sv
// tb_mod_symbol_sequencer: three parameterisations checked against a symbol-timeline model
module tb_mod_symbol_sequencer;
  typedef struct {
    logic [1:0] sel;
    bit stb;
    bit fin;
  } ent_t;
  typedef struct {
    int inst;
    int cyc;
    bit drv;
    logic [7:0] dat;
    logic [5:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld[3];
  logic [7:0] dat[3];
  logic [1:0] sel_o[3];
  logic stb_o[3], busy_o[3], done_o[3], rdy_o[3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mod_symbol_sequencer_if ifc ();
    assign ifc.in_valid = vld[g];
    assign ifc.in_data = dat[g];
    assign sel_o[g] = ifc.sel;
    assign stb_o[g] = ifc.sym_strobe;
    assign busy_o[g] = ifc.busy;
    assign done_o[g] = ifc.burst_done;
    assign rdy_o[g] = ifc.in_ready;
    mod_symbol_sequencer #(
      .SYM_CYCLES(g == 1 ? 1 : 4),
      .PREAMBLE_SYMS(g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .IDLE_SEL(2'd0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
    );
  end
  function automatic int sc(int i);
    return i == 1 ? 1 : 4;
  endfunction
  function automatic int ps(int i);
    return i == 0 ? 2 : (i == 1 ? 1 : 4);
  endfunction
  // model: a queue of future output cycles; each symbol is sc cycles, fin marks a segment end
  ent_t tl[3][$];
  bit hv[3];
  logic [7:0] hb[3];
  bit dn[3];
  task automatic push_sym(int i, logic [1:0] s, bit fin);
    for (int k = 0; k < sc(i); k++) tl[i].push_back(ent_t'{sel: s, stb: (k == 0), fin: (fin && k == sc(i) - 1)});
  endtask
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        tl[i].delete();
        hv[i] = 1'b0;
        dn[i] = 1'b0;
      end else begin
        automatic bit hs = vld[i] && !hv[i];
        automatic ent_t e;
        dn[i] = 1'b0;
        if (tl[i].size() > 0) begin
          e = tl[i].pop_front();
          if (e.fin) begin
            if (hv[i]) begin
              for (int j = 0; j < 4; j++) push_sym(i, hb[i][7-2*j -: 2], j == 3);
              hv[i] = 1'b0;
            end else dn[i] = 1'b1;
          end
        end else if (hv[i]) begin
          for (int p = 0; p < ps(i); p++) push_sym(i, (p % 2) ? 2'b11 : 2'b00, p == ps(i) - 1);
        end
        if (hs) begin
          hv[i] = 1'b1;
          hb[i] = dat[i];
        end
      end
    end
  end
  function automatic logic [5:0] mexp(int i);
    logic [1:0] s = 2'b00;
    logic b = 1'b0;
    if (tl[i].size() > 0) begin
      s = tl[i][0].sel;
      b = tl[i][0].stb;
    end
    return {s, b, tl[i].size() > 0, dn[i], !hv[i]};
  endfunction
  function automatic logic [5:0] dut(int i);
    return {sel_o[i], stb_o[i], busy_o[i], done_o[i], rdy_o[i]};
  endfunction
  task automatic chk(string nm, int i, logic [5:0] got, logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got {sel,stb,busy,done,rdy}=%b expected %b", nm, i, $time, got, exp);
    end
  endtask
  task automatic chki(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, got, exp);
    end
  endtask
  bit pend[3];
  logic [7:0] pdat[3];
  bit rprev[3];
  int acc[3];
  logic [7:0] q[3][$];
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk("model", i, dut(i), mexp(i));
        if (vld[i] && rprev[i]) begin
          pend[i] = 1'b0;
          acc[i]++;
        end
      end
    end
  endtask
  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      vld[i] = pend[i];
      dat[i] = pend[i] ? pdat[i] : 8'($urandom);
      rprev[i] = rdy_o[i];
    end
  endtask
  vec_t tv[$];
  task automatic drive(int i, int c, logic [7:0] d);
    tv.push_back(vec_t'{inst: i, cyc: c, drv: 1'b1, dat: d, exp: 6'b0});
  endtask
  task automatic expect_at(int i, int c, logic [5:0] e);
    tv.push_back(vec_t'{inst: i, cyc: c, drv: 1'b0, dat: 8'h00, exp: e});
  endtask
  initial begin
    int nd, base[3];
    bit sent, all_idle;
    // vectors: {sel,stb,busy,done,rdy} at cycle c relative to the first handshake cycle
    drive(0, 0, 8'hB4);
    expect_at(0, 0, 6'b000001); expect_at(0, 1, 6'b000000); expect_at(0, 2, 6'b001100);
    expect_at(0, 5, 6'b000100); expect_at(0, 6, 6'b111100); expect_at(0, 9, 6'b110100);
    expect_at(0, 10, 6'b101101); expect_at(0, 13, 6'b100101); expect_at(0, 14, 6'b111101);
    expect_at(0, 18, 6'b011101); expect_at(0, 22, 6'b001101); expect_at(0, 25, 6'b000101);
    expect_at(0, 26, 6'b000011); expect_at(0, 27, 6'b000001);
    drive(0, 28, 8'h5A); drive(0, 54, 8'hC3);
    expect_at(0, 53, 6'b100101); expect_at(0, 54, 6'b000011); expect_at(0, 55, 6'b000000);
    expect_at(0, 56, 6'b001100);
    drive(1, 0, 8'h27);
    expect_at(1, 1, 6'b000000); expect_at(1, 2, 6'b001100); expect_at(1, 3, 6'b001101);
    expect_at(1, 4, 6'b101101); expect_at(1, 5, 6'b011101); expect_at(1, 6, 6'b111101);
    expect_at(1, 7, 6'b000011); expect_at(1, 8, 6'b000001);
    drive(2, 0, 8'h1B); drive(2, 1, 8'hE4);
    expect_at(2, 2, 6'b001100); expect_at(2, 6, 6'b111100); expect_at(2, 10, 6'b001100);
    expect_at(2, 14, 6'b111100); expect_at(2, 17, 6'b110100); expect_at(2, 18, 6'b001101);
    expect_at(2, 19, 6'b000100); expect_at(2, 22, 6'b011100); expect_at(2, 26, 6'b101100);
    expect_at(2, 30, 6'b111100); expect_at(2, 34, 6'b111101); expect_at(2, 38, 6'b101101);
    expect_at(2, 42, 6'b011101); expect_at(2, 46, 6'b001101); expect_at(2, 49, 6'b000101);
    expect_at(2, 50, 6'b000011);
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
      pend[i] = 1'b0;
      rprev[i] = 1'b0;
      acc[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset", i, dut(i), 6'b000001);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      cyc();
      foreach (tv[k]) begin
        if (tv[k].cyc == c) begin
          if (tv[k].drv) begin
            pend[tv[k].inst] = 1'b1;
            pdat[tv[k].inst] = tv[k].dat;
          end else chk("vec", tv[k].inst, dut(tv[k].inst), tv[k].exp);
        end
      end
      if (done_o[2]) nd++;
      apply();
    end
    chki("b2b_done_count", nd, 1);
    for (int i = 0; i < 3; i++) begin
      base[i] = acc[i];
      for (int k = 0; k < 16; k++) q[i].push_back(8'($urandom));
    end
    all_idle = 1'b0;
    for (int c = 0; c < 4000 && !all_idle; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && q[i].size() > 0 && $urandom_range(3) != 0) begin
          pend[i] = 1'b1;
          pdat[i] = q[i].pop_front();
        end
      end
      apply();
      all_idle = 1'b1;
      for (int i = 0; i < 3; i++)
        if (q[i].size() > 0 || pend[i] || busy_o[i] || !rdy_o[i]) all_idle = 1'b0;
    end
    chki("drain_idle", int'(all_idle), 1);
    for (int i = 0; i < 3; i++) chki("accepted_bytes", acc[i] - base[i], 16);
    pend[2] = 1'b1;
    pdat[2] = 8'hA5;
    sent = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      if (!pend[2] && !sent) begin
        pend[2] = 1'b1;
        pdat[2] = 8'h3C;
        sent = 1'b1;
      end
      apply();
    end
    chki("pre_rst_busy", int'(busy_o[2]), 1);
    chki("pre_rst_ready", int'(rdy_o[2]), 0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("async_rst", i, dut(i), 6'b000001);
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      vld[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) chki("idle_sel", int'(sel_o[i]), 0);
      apply();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
